// File: rtl/branch_target_buffer.sv
// Branch target buffer: 16-entry direct-mapped table of taken-branch targets
// with 2-bit saturating direction counters. Lookup is combinational from the
// registered table; resolved-branch updates are written on the rising edge.
// Optional feature macro: BTB_BYPASS_EN. When it is defined, a same-index
// update is forwarded combinationally into the lookup of the same cycle.
module branch_target_buffer (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] InstrAddr,
  output logic [31:0] Predict,
  output logic        PCSource,
  output logic        PredHit,
  input  logic        UpdValid,
  input  logic [31:0] UpdAddr,
  input  logic        UpdTaken,
  input  logic [31:0] UpdTarget,
  input  logic        Invalidate
);

  localparam int ENTRIES = 16;

  logic [ENTRIES-1:0] r_valid;
  logic [25:0]        r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [3:0]  w_updIdx;
  logic        w_updHit;
  logic        w_updWrite;
  logic        w_newValid;
  logic [25:0] w_newTag;
  logic [31:0] w_newTarget;
  logic [1:0]  w_newCtr;

  logic [3:0]  w_lkIdx;
  logic        w_selValid;
  logic [25:0] w_selTag;
  logic [31:0] w_selTarget;
  logic [1:0]  w_selCtr;
  logic        w_hit;
  logic        w_pcSource;
  logic        w_unused;

  // The two byte-offset bits never take part in indexing or tagging.
  assign w_unused = ^{InstrAddr[1:0], UpdAddr[1:0]};

  assign w_updIdx = UpdAddr[5:2];
  assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == UpdAddr[31:6]);

  // Compute the post-update contents of the entry addressed by the update.
  always_comb begin
    w_updWrite  = 1'b0;
    w_newValid  = r_valid[w_updIdx];
    w_newTag    = r_tag[w_updIdx];
    w_newTarget = r_target[w_updIdx];
    w_newCtr    = r_ctr[w_updIdx];
    if (w_updHit) begin
      w_updWrite = 1'b1;
      if (UpdTaken) begin
        w_newCtr    = (r_ctr[w_updIdx] == 2'b11) ? 2'b11 : r_ctr[w_updIdx] + 2'd1;
        w_newTarget = UpdTarget;
      end else begin
        w_newCtr = (r_ctr[w_updIdx] == 2'b00) ? 2'b00 : r_ctr[w_updIdx] - 2'd1;
      end
    end else if (UpdTaken) begin
      w_updWrite  = 1'b1;
      w_newValid  = 1'b1;
      w_newTag    = UpdAddr[31:6];
      w_newTarget = UpdTarget;
      w_newCtr    = 2'b10;
    end
  end

  // Table state: reset to weakly-not-taken, Invalidate wins over any update.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (Invalidate) begin
      r_valid <= '0;
    end else if (UpdValid && w_updWrite) begin
      r_valid[w_updIdx]  <= w_newValid;
      r_tag[w_updIdx]    <= w_newTag;
      r_target[w_updIdx] <= w_newTarget;
      r_ctr[w_updIdx]    <= w_newCtr;
    end
  end

  assign w_lkIdx = InstrAddr[5:2];

`ifdef BTB_BYPASS_EN
  logic w_bypass;
  // Forwarding is held off during reset so the outputs stay quiet there.
  assign w_bypass = Rst_n && UpdValid && !Invalidate && (w_updIdx == w_lkIdx);
`endif

  // Select the entry seen by the lookup, either stored or forwarded.
  always_comb begin
    w_selValid  = r_valid[w_lkIdx];
    w_selTag    = r_tag[w_lkIdx];
    w_selTarget = r_target[w_lkIdx];
    w_selCtr    = r_ctr[w_lkIdx];
`ifdef BTB_BYPASS_EN
    if (w_bypass) begin
      w_selValid  = w_newValid;
      w_selTag    = w_newTag;
      w_selTarget = w_newTarget;
      w_selCtr    = w_newCtr;
    end
`endif
  end

  assign w_hit      = w_selValid && (w_selTag == InstrAddr[31:6]);
  assign w_pcSource = w_hit && w_selCtr[1];

  assign PredHit  = w_hit;
  assign PCSource = w_pcSource;
  assign Predict  = w_pcSource ? w_selTarget : (InstrAddr + 32'd4);

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with
// literal expectations plus a randomized run against a behavioural table.
module tb_branch_target_buffer;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] InstrAddr;
  logic [31:0] Predict;
  logic        PCSource;
  logic        PredHit;
  logic        UpdValid;
  logic [31:0] UpdAddr;
  logic        UpdTaken;
  logic [31:0] UpdTarget;
  logic        Invalidate;

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  branch_target_buffer dut (
    .Clk(Clk), .Rst_n(Rst_n), .InstrAddr(InstrAddr), .Predict(Predict),
    .PCSource(PCSource), .PredHit(PredHit), .UpdValid(UpdValid),
    .UpdAddr(UpdAddr), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget),
    .Invalidate(Invalidate)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    bit          v;
    logic [25:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  ent_t mdl [16];

  // Behavioural view of one entry after a resolved branch is applied to it.
  function automatic ent_t afterUpdate(ent_t e, logic [31:0] ua, bit taken, logic [31:0] utg);
    ent_t n;
    bit hit;
    n = e;
    hit = e.v && (e.tag == ua[31:6]);
    if (hit && taken) begin
      n.ctr = (e.ctr < 3) ? e.ctr + 1 : 3;
      n.tgt = utg;
    end else if (hit) begin
      n.ctr = (e.ctr > 0) ? e.ctr - 1 : 0;
    end else if (taken) begin
      n.v = 1; n.tag = ua[31:6]; n.tgt = utg; n.ctr = 2;
    end
    return n;
  endfunction

  // Reference table follows reset, invalidate and update strobes.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 16; i++) mdl[i] <= '{0, 26'd0, 32'd0, 1};
    end else if (Invalidate) begin
      for (int i = 0; i < 16; i++) mdl[i].v <= 0;
    end else if (UpdValid) begin
      mdl[int'(UpdAddr[5:2])] <= afterUpdate(mdl[int'(UpdAddr[5:2])], UpdAddr, UpdTaken, UpdTarget);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge, compare all outputs with the reference lookup.
  always @(negedge Clk) begin
    if (checkEn) begin
      ent_t e;
      bit expHit, expPcs;
      logic [31:0] expPred;
      e = mdl[int'(InstrAddr[5:2])];
`ifdef BTB_BYPASS_EN
      if (Rst_n && UpdValid && !Invalidate && UpdAddr[5:2] == InstrAddr[5:2])
        e = afterUpdate(e, UpdAddr, UpdTaken, UpdTarget);
`endif
      expHit  = e.v && (e.tag == InstrAddr[31:6]);
      expPcs  = expHit && (e.ctr >= 2);
      expPred = expPcs ? e.tgt : InstrAddr + 32'd4;
      checkOutput("model_hit", PredHit, expHit);
      checkOutput("model_pcsource", PCSource, expPcs);
      checkOutput("model_predict", Predict, expPred);
    end
  end

  task automatic applyStimulus(input logic [31:0] ia, input logic uv, input logic [31:0] ua,
                               input logic ut, input logic [31:0] utg, input logic inv);
    @(posedge Clk);
    #1;
    InstrAddr  = ia;
    UpdValid   = uv;
    UpdAddr    = ua;
    UpdTaken   = ut;
    UpdTarget  = utg;
    Invalidate = inv;
  endtask

  task automatic lookupCheck(input string name, input logic [31:0] ia, input logic hit,
                             input logic pcs, input logic [31:0] pred);
    applyStimulus(ia, 0, 32'h0, 0, 32'h0, 0);
    #2;
    checkOutput({name, "_hit"}, PredHit, hit);
    checkOutput({name, "_pcs"}, PCSource, pcs);
    checkOutput({name, "_pred"}, Predict, pred);
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) a = 32'hFFFF_FFFC;
    else if (sel < 3) a = $urandom;
    else a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00};
    return a;
  endfunction

  initial begin
    Rst_n = 0; InstrAddr = 32'h10; UpdValid = 0; UpdAddr = 0;
    UpdTaken = 0; UpdTarget = 0; Invalidate = 0;
    #3;
    checkOutput("reset_hit", PredHit, 0);
    checkOutput("reset_pcs", PCSource, 0);
    checkOutput("reset_pred", Predict, 32'h14);
    #9;
    Rst_n = 1;
    checkEn = 1;

    // Miss allocation; the same-cycle lookup shows old or forwarded contents.
    applyStimulus(32'h100, 1, 32'h100, 1, 32'h200, 0);
    #2;
`ifdef BTB_BYPASS_EN
    checkOutput("same_cycle_hit", PredHit, 1);
    checkOutput("same_cycle_pred", Predict, 32'h200);
`else
    checkOutput("same_cycle_hit", PredHit, 0);
    checkOutput("same_cycle_pred", Predict, 32'h104);
`endif
    lookupCheck("alloc", 32'h100, 1, 1, 32'h200);

    // Counter hysteresis: 10 -> 01 -> 00 -> 01.
    applyStimulus(32'h100, 1, 32'h100, 0, 32'h0, 0);
    applyStimulus(32'h100, 1, 32'h100, 0, 32'h0, 0);
    #2;
    checkOutput("hyst1_pcs", PCSource, 0);
    checkOutput("hyst1_pred", Predict, 32'h104);
    applyStimulus(32'h100, 1, 32'h100, 1, 32'h200, 0);
    lookupCheck("hyst3", 32'h100, 1, 0, 32'h104);

    // Tag conflict at index 0 replaces the older branch.
    applyStimulus(32'h140, 1, 32'h140, 1, 32'h300, 0);
    lookupCheck("conflict_old", 32'h100, 0, 0, 32'h104);
    lookupCheck("conflict_new", 32'h140, 1, 1, 32'h300);

    // Invalidate beats a simultaneous taken update.
    applyStimulus(32'h140, 1, 32'h180, 1, 32'h400, 1);
    #2;
    checkOutput("inv_same_cycle_hit", PredHit, 1);
    lookupCheck("inv_old", 32'h140, 0, 0, 32'h144);
    lookupCheck("inv_upd", 32'h180, 0, 0, 32'h184);

    // Mid-run reset with a coincident update that must be abandoned.
    applyStimulus(32'h100, 1, 32'h100, 1, 32'h200, 0);
    lookupCheck("pre_rst", 32'h100, 1, 1, 32'h200);
    Rst_n = 0;
    InstrAddr = 32'hFFFF_FFFC;
    UpdValid = 1; UpdAddr = 32'h100; UpdTaken = 1; UpdTarget = 32'h500;
    #1;
    checkOutput("rst_hit", PredHit, 0);
    checkOutput("rst_pcs", PCSource, 0);
    checkOutput("rst_wrap_pred", Predict, 32'h0);
    @(posedge Clk);
    #3;
    Rst_n = 1;
    UpdValid = 0;
    InstrAddr = 32'h100;
    #1;
    checkOutput("post_rst_hit", PredHit, 0);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(randAddr(), 1'($urandom_range(0, 2) != 0), randAddr(),
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 40) == 0));
      if (n % 150 == 149) begin
        #2 Rst_n = 0;
        @(posedge Clk);
        #3 Rst_n = 1;
      end
    end

    @(posedge Clk);
    #1;
    checkEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have port Clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port InstrAddr, input, 32, current fetch address from the PC stage, used for lookup.
REQ-004 SHALL have port Predict, output, 32, predicted next fetch address, driven to the PC stage.
REQ-005 SHALL have port PCSource, output, 1, 1 = PC stage selects Predict; driven to the PC stage.
REQ-006 SHALL have port PredHit, output, 1, lookup tag hit, regardless of direction; carried down the pipe.
REQ-007 SHALL have port UpdValid, input, 1, resolved branch update strobe from execute.
REQ-008 SHALL have port UpdAddr, input, 32, address of the resolved branch.
REQ-009 SHALL have port UpdTaken, input, 1, resolved direction, 1 = taken.
REQ-010 SHALL have port UpdTarget, input, 32, resolved taken target.
REQ-011 SHALL have port Invalidate, input, 1, synchronous clear of all valid bits.

Function
REQ-012 SHALL be a 16-entry direct-mapped table; index = addr[5:2], tag = addr[31:6].
REQ-013 SHALL give each entry: valid (1b), tag (26b), target (32b), counter (2b saturating).
REQ-014 SHALL perform lookup combinationally from registered table state, with zero-cycle latency.
REQ-015 SHALL assert PredHit when valid[idx] is set and tag[idx] equals InstrAddr[31:6].
REQ-016 SHALL drive PCSource = PredHit AND counter[idx][1].
REQ-017 SHALL drive Predict = target[idx] when PCSource=1, else InstrAddr+32'd4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000).
REQ-018 SHALL apply updates on the rising edge when UpdValid=1; there is no ready signal and every strobe is accepted.
REQ-019 SHALL, on an update hit with UpdTaken=1, increment the counter (saturating at 2'b11) and write target to UpdTarget.
REQ-020 SHALL, on an update hit with UpdTaken=0, decrement the counter (saturating at 2'b00) and leave target unchanged.
REQ-021 SHALL, on an update miss with UpdTaken=1, allocate or replace the entry: valid=1, tag, target=UpdTarget, counter=2'b10.
REQ-022 SHALL, on an update miss with UpdTaken=0, leave the table unchanged.
REQ-023 SHALL clear all valid bits on the edge when Invalidate=1, and SHALL ignore any update in that same cycle; counters and targets are not cleared.
REQ-024 SHALL, without a bypass, return pre-update contents for a lookup and an update to the same index in the same cycle.
REQ-025 SHALL have no internal knowledge of pipeline flush or PC-stall conditions; stalls simply repeat the lookup.

Reset
REQ-026 SHALL, while Rst_n=0, asynchronously force all valid=0, counters=2'b01, tags=0 and targets=0.
REQ-027 SHALL, during and immediately after reset, give PredHit=0, PCSource=0 and Predict=InstrAddr+4.
REQ-028 SHALL abandon any update coincident with reset assertion; it has no effect after reset release.

Configuration
REQ-029 SHALL implement a same-index write-to-read bypass when macro BTB_BYPASS_EN is defined.
REQ-030 SHALL, with BTB_BYPASS_EN defined, return the post-update entry for a lookup when UpdValid=1, Invalidate=0 and UpdAddr[5:2]==InstrAddr[5:2] in the same cycle; this is a combinational forward.
REQ-031 SHALL, without BTB_BYPASS_EN, behave per REQ-024.

Verification
REQ-032 SHALL cover miss allocation: after reset, update addr 0x00000100, taken, target 0x00000200 -> lookup 0x00000100 gives PredHit=1, PCSource=1, Predict=0x00000200.
REQ-033 SHALL cover counter hysteresis: from the REQ-032 state, one not-taken update -> PCSource=0, Predict=0x00000104; a second not-taken, then one taken -> PCSource=0 (counter 2'b01).
REQ-034 SHALL cover tag conflict: allocate 0x00000100, then taken-update 0x00000140 with target 0x00000300 -> lookup 0x00000100 misses, and lookup 0x00000140 gives Predict=0x00000300.
REQ-035 SHALL cover the same-cycle case: lookup and update of 0x00000100 in one cycle -> without macro, old result that cycle and new the next; with BTB_BYPASS_EN, new result in the same cycle.
REQ-036 SHALL cover Invalidate and reset: Invalidate plus a simultaneous taken update -> all lookups miss next cycle; Rst_n pulse mid-run -> PredHit=0 immediately, and lookup 0xFFFFFFFC gives Predict=0x00000000.
